mult_share_arb: RTL and testbench
=================================

# mult_share_arb

Two-requester arbiter and sequencer for the shared 5x5 unsigned array multiplier in the tt_um_b_5_array_multiplier project. It accepts operand pairs from two clients over valid/ack handshakes, chooses one per operation, and drives the combinational multiplier core. It captures the 10-bit product and returns it, tagged with the requester ID, over a valid/ready response port. It sits between the top-level pin decode and the multiplier core.

## Interface
Parameters:
- W, 5, operand width; product width is 2*W

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  design enable; low blocks new grants
- req0 / req1  in  1  requester valid
- a0, b0 / a1, b1  in  W  requester operands; must be stable while req is high and ack is low
- ack0 / ack1  out  1  combinational accept; transfer on rising edge with req_i && ack_i
- mul_a, mul_b  out  W  registered operands to multiplier core
- mul_p  in  2W  combinational product from core
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer ready
- rsp_id  out  1  requester index of response
- rsp_prod  out  2W  product
- busy  out  1  high in EXEC or RESP
- op_count  out  8  completed-response counter, wraps 255->0

## Operation
- States: IDLE, EXEC, RESP.
- IDLE:
  - if ena && (req0 || req1), assert ack for exactly one winner;
  - latch the winner's a/b into mul_a/mul_b and its index into rsp_id;
  - go to EXEC.
  - No ack when ena=0.
- EXEC (1 cycle): the core settles; capture mul_p into rsp_prod; go to RESP.
- RESP: rsp_valid=1. On rsp_valid && rsp_ready, increment op_count and go to IDLE. No ack is issued in EXEC or RESP.
- Arbitration is round-robin. A last-grant pointer updates on every grant. If both requesters are active, the non-last one wins; a single requester always wins.
- ena falling mid-operation does not abort; the operation completes normally.
- rsp_prod, rsp_id and mul_a/b hold their values until the next grant.
- Product arithmetic is unsigned: 31*31=961 (0x3C1) is the maximum and never overflows 2W bits.

## Timing
- Reset values:
  - state=IDLE; ack0/1=0; rsp_valid=0; rsp_id=0; rsp_prod=0; mul_a=mul_b=0; busy=0; op_count=0.
  - Last-grant pointer=1, so req0 wins the first tie.
- Latency from transfer edge (cycle N):
  - mul_a/mul_b valid in N+1 (EXEC);
  - rsp_valid high in N+2.
- Minimum issue interval with rsp_ready=1 is 3 cycles (IDLE, EXEC, RESP).
- rsp_valid stays high and rsp_prod/rsp_id stay stable until accepted; backpressure is unbounded.
- busy is high in exactly the EXEC and RESP cycles.
- Asynchronous reset in any state immediately forces all reset values; a held response is lost.

## Configuration
- MSA_FIXED_PRIO_EN defined: fixed priority, req0 always beats req1, and the last-grant pointer is not implemented.
- MSA_FIXED_PRIO_EN undefined (default): round-robin as described above.

## Test plan
- Reset, then req0 with a0=5, b0=7 and rsp_ready=1 -> ack0 in cycle 0; rsp_valid in cycle 2 with rsp_id=0, rsp_prod=35; op_count=1.
- req0 and req1 held together with operands 31*31 and 3*4, rsp_ready=1 -> responses alternate id 0 (961), 1 (12), 0, 1. With MSA_FIXED_PRIO_EN, all responses are id 0.
- Hold rsp_ready=0 for 10 cycles after a response with 2*9 -> rsp_valid and rsp_prod=18 stay stable; ack0/ack1 stay 0 despite pending requests. Release rsp_ready -> IDLE on the next cycle.
- ena=0 with req1 high -> no ack1. Drop ena during EXEC -> the response still arrives.
- Assert rst_n=0 in RESP -> rsp_valid=0, op_count=0 and busy=0 immediately; the next tie is granted to req0.
- Run 256 accepted responses -> op_count wraps to 0.

Source files
------------

// File: rtl/mult_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : mult_share_arb
// Description : Two-requester arbiter/sequencer for the shared 5x5 unsigned
//               array multiplier. Grants one requester per operation, drives
//               registered operands to the combinational multiplier core,
//               captures the product and returns it tagged with the
//               requester index over a valid/ready response port.
//
// Ports       : clk, rst_n          - clock, asynchronous active-low reset
//               ena                 - enable; low blocks new grants
//               req0/1, a0/b0, a1/b1- requester valid and operands
//               ack0/1              - combinational accept (IDLE only)
//               mul_a, mul_b, mul_p - multiplier core operands / product
//               rsp_valid/ready     - response handshake
//               rsp_id, rsp_prod    - response requester index and product
//               busy                - high while in EXEC or RESP
//               op_count            - completed responses, wraps 255 -> 0
//
// Options     : MSA_FIXED_PRIO_EN - when defined, req0 always beats req1 and
//               no last-grant pointer exists; otherwise round-robin.
//
// Revision    : 1.0 - initial release
// ============================================================================
module mult_share_arb #(
    parameter int W = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    input  logic           req0,
    input  logic [W-1:0]   a0,
    input  logic [W-1:0]   b0,
    input  logic           req1,
    input  logic [W-1:0]   a1,
    input  logic [W-1:0]   b1,
    output logic           ack0,
    output logic           ack1,
    output logic [W-1:0]   mul_a,
    output logic [W-1:0]   mul_b,
    input  logic [2*W-1:0] mul_p,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [2*W-1:0] rsp_prod,
    output logic           busy,
    output logic [7:0]     op_count
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic       w_grant;   // a transfer happens at the next rising edge
    logic       w_win;     // index of the requester that wins this cycle

    assign w_grant = (r_state == c_IDLE) && ena && (req0 || req1);

`ifdef MSA_FIXED_PRIO_EN
    assign w_win = ~req0;
`else
    // Last-grant pointer resets to 1 so that req0 takes the first tie.
    logic r_last;

    // On a tie the requester that did not win last time goes next;
    // a lone requester always wins.
    assign w_win = (req0 && req1) ? ~r_last : ~req0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (w_grant) begin
            r_last <= w_win;
        end
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: if (w_grant) w_next_state = c_EXEC;
            c_EXEC: w_next_state = c_RESP;
            c_RESP: if (rsp_ready) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        ack0      = w_grant && !w_win;
        ack1      = w_grant &&  w_win;
        rsp_valid = (r_state == c_RESP);
        busy      = (r_state == c_EXEC) || (r_state == c_RESP);
    end

    // Datapath: operands and tag are latched on the grant, the product one
    // cycle later once the combinational core has settled. All hold until
    // the next grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a    <= '0;
            mul_b    <= '0;
            rsp_id   <= 1'b0;
            rsp_prod <= '0;
            op_count <= 8'd0;
        end else begin
            if (w_grant) begin
                mul_a  <= w_win ? a1 : a0;
                mul_b  <= w_win ? b1 : b0;
                rsp_id <= w_win;
            end
            if (r_state == c_EXEC) begin
                rsp_prod <= mul_p;
            end
            if ((r_state == c_RESP) && rsp_ready) begin
                op_count <= op_count + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_share_arb
// Description : Scoreboard bench for mult_share_arb. Stimulus pushes the
//               expected {id, product} of each grant; a monitor pops and
//               compares on every accepted response and tracks op_count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_share_arb;

    localparam int W = 5;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           ena = 1'b0;
    logic           req0 = 1'b0;
    logic           req1 = 1'b0;
    logic [W-1:0]   a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic           ack0, ack1;
    logic [W-1:0]   mul_a, mul_b;
    logic [2*W-1:0] mul_p;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic           rsp_id;
    logic [2*W-1:0] rsp_prod;
    logic           busy;
    logic [7:0]     op_count;

    int checks   = 0;
    int failures = 0;

    logic [2*W:0] exp_q[$];           // {id, product}
    logic [7:0]   exp_cnt  = 8'd0;
    logic         acc_pend = 1'b0;

    // Behavioural stand-in for the combinational multiplier core
    assign mul_p = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};

    mult_share_arb #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_prod(rsp_prod),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares every accepted response and the following op_count
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_cnt  = 8'd0;
            acc_pend = 1'b0;
        end else begin
            if (acc_pend) begin
                chk("op_count", {24'd0, op_count}, {24'd0, exp_cnt});
                acc_pend = 1'b0;
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp actual=id%0d/%0d required=none", rsp_id, rsp_prod);
                end else begin
                    logic [2*W:0] e;
                    e = exp_q.pop_front();
                    chk("rsp_id", {31'd0, rsp_id}, {31'd0, e[2*W]});
                    chk("rsp_prod", {22'd0, rsp_prod}, {22'd0, e[2*W-1:0]});
                end
                exp_cnt  = exp_cnt + 8'd1;
                acc_pend = 1'b1;
            end
        end
    end

    // Waits (bounded) for an ack; returns at the negedge of the grant cycle
    task automatic wait_grant(output logic g1);
        int n = 0;
        @(negedge clk);
        while (!(ack0 || ack1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!(ack0 || ack1)) chk("grant_timeout", 32'd0, 32'd1);
        g1 = ack1;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || busy) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic       g;
        logic       eid;
        logic [W-1:0] ta, tb;

        // Reset state
        #2;
        chk("rst_ack0", {31'd0, ack0}, 0);
        chk("rst_ack1", {31'd0, ack1}, 0);
        chk("rst_valid", {31'd0, rsp_valid}, 0);
        chk("rst_id", {31'd0, rsp_id}, 0);
        chk("rst_prod", {22'd0, rsp_prod}, 0);
        chk("rst_mul", {22'd0, mul_a, mul_b}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_cnt", {24'd0, op_count}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single request 5*7, with latency checks
        @(posedge clk); #1;
        ena = 1'b1; rsp_ready = 1'b1; a0 = 5; b0 = 7; req0 = 1'b1;
        wait_grant(g);
        chk("t1_ack0", {31'd0, ack0}, 1);
        chk("t1_ack1", {31'd0, ack1}, 0);
        exp_q.push_back({1'b0, 10'd35});
        @(posedge clk); #1 req0 = 1'b0;
        @(negedge clk);
        chk("t1_exec_busy", {31'd0, busy}, 1);
        chk("t1_mul", {22'd0, mul_a, mul_b}, {22'd0, 5'd5, 5'd7});
        chk("t1_exec_valid", {31'd0, rsp_valid}, 0);
        @(negedge clk);
        chk("t1_resp_valid", {31'd0, rsp_valid}, 1);
        wait_idle();

        // Lone req1 6*9; leaves the pointer on 1
        @(posedge clk); #1;
        a1 = 6; b1 = 9; req1 = 1'b1;
        wait_grant(g);
        chk("t2_id", {31'd0, g}, 1);
        exp_q.push_back({1'b1, 10'd54});
        @(posedge clk); #1 req1 = 1'b0;
        wait_idle();

        // Tie: 31*31 vs 3*4 held for four grants
        @(posedge clk); #1;
        a0 = 31; b0 = 31; a1 = 3; b1 = 4; req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef MSA_FIXED_PRIO_EN
            eid = 1'b0;
`else
            eid = k[0];
`endif
            wait_grant(g);
            chk("tie_id", {31'd0, g}, {31'd0, eid});
            exp_q.push_back({eid, eid ? 10'd12 : 10'd961});
            @(posedge clk); #1;
        end
        req0 = 1'b0; req1 = 1'b0;
        wait_idle();

        // Backpressure: 2*9 held for 10 cycles with both requests pending
        @(posedge clk); #1;
        rsp_ready = 1'b0; a0 = 2; b0 = 9; req0 = 1'b1;
        wait_grant(g);
        chk("bp_id", {31'd0, g}, 0);
        exp_q.push_back({1'b0, 10'd18});
        @(posedge clk); #1 req1 = 1'b1;
        @(negedge clk); @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            chk("bp_valid", {31'd0, rsp_valid}, 1);
            chk("bp_prod", {22'd0, rsp_prod}, 18);
            chk("bp_ack", {30'd0, ack0, ack1}, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle", {30'd0, busy, rsp_valid}, 0);

        // ena low blocks grants; dropping ena during EXEC does not abort
        @(posedge clk); #1;
        ena = 1'b0; a1 = 1; b1 = 1; req1 = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("ena_no_ack1", {31'd0, ack1}, 0);
        end
        @(posedge clk); #1;
        ena = 1'b1; a1 = 7; b1 = 3;
        wait_grant(g);
        chk("ena_id", {31'd0, g}, 1);
        exp_q.push_back({1'b1, 10'd21});
        @(posedge clk); #1;
        req1 = 1'b0; ena = 1'b0;
        @(negedge clk);
        chk("ena_exec_busy", {31'd0, busy}, 1);
        wait_idle();
        ena = 1'b1;

        // Asynchronous reset while a response is held
        @(posedge clk); #1;
        rsp_ready = 1'b0; a0 = 4; b0 = 4; req0 = 1'b1;
        wait_grant(g);
        @(posedge clk); #1 req0 = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        chk("pre_rst_valid", {31'd0, rsp_valid}, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, rsp_valid}, 0);
        chk("arst_cnt", {24'd0, op_count}, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; rsp_ready = 1'b1;
        a0 = 3; b0 = 5; a1 = 2; b1 = 2; req0 = 1'b1; req1 = 1'b1;
        wait_grant(g);
        chk("arst_tie_id", {31'd0, g}, 0);
        exp_q.push_back({1'b0, 10'd15});
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        wait_idle();

        // 255 more accepted responses: op_count wraps to 0
        for (int k = 0; k < 255; k++) begin
            @(posedge clk); #1;
            ta = 5'(k % 32);
            tb = 5'(31 - (k % 32));
            a0 = ta; b0 = tb; req0 = 1'b1;
            wait_grant(g);
            exp_q.push_back({1'b0, {5'd0, ta} * {5'd0, tb}});
            @(posedge clk); #1 req0 = 1'b0;
        end
        wait_idle();
        chk("wrap_cnt", {24'd0, op_count}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
